// File: rtl/dec_accumulator_pkg.sv
// Shared definitions for the decrementing accumulator: FSM encoding and the
// active-low 7-segment glyph table (segment g is bit 6).
package dec_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    // Entry n is the glyph for hex digit n; the first listed value is digit F.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        return SEG_GLYPH[digit];
    endfunction

endpackage

// File: rtl/full_sub_8_bit.sv
// 8-bit subtractor: diff = x - y, with unsigned borrow and signed overflow.
module full_sub_8_bit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] diff,
    output logic       borrow,
    output logic       overflow
);

    logic [8:0] wide;

    always_comb begin
        wide     = {1'b0, x} - {1'b0, y};
        diff     = wide[7:0];
        borrow   = wide[8];
        overflow = (x[7] != y[7]) && (wide[7] != x[7]);
    end

endmodule

// File: rtl/dec_accumulator.sv
// Load/decrement accumulator with IDLE/RUN/ZERO FSM and hex display decodes.
// Optional macro DEC_ACC_SAT_EN clamps a borrowing step to zero.
module dec_accumulator
    import dec_accumulator_pkg::*;
#(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic       load,
    input  logic       step,
    output logic [7:0] acc,
    output logic       b,
    output logic       v,
    output logic       done,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output state_t     fsm_state
);

    state_t     state_q, state_d;
    logic [7:0] acc_d;
    logic       b_d, v_d;
    logic [7:0] sub_diff;
    logic       sub_borrow, sub_overflow;

    full_sub_8_bit u_sub (
        .x        (acc),
        .y        (a),
        .diff     (sub_diff),
        .borrow   (sub_borrow),
        .overflow (sub_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc     <= INIT;
            b       <= 1'b0;
            v       <= 1'b0;
        end else begin
            state_q <= state_d;
            acc     <= acc_d;
            b       <= b_d;
            v       <= v_d;
        end
    end

    // Load wins over step; step only acts in RUN.
    always_comb begin
        state_d = state_q;
        acc_d   = acc;
        b_d     = b;
        v_d     = v;
        if (load) begin
            acc_d   = a;
            b_d     = 1'b0;
            v_d     = 1'b0;
            state_d = (a == 8'h00) ? ZERO : RUN;
        end else if (step && state_q == RUN) begin
            b_d = sub_borrow;
            v_d = sub_overflow;
`ifdef DEC_ACC_SAT_EN
            if (sub_borrow) begin
                acc_d   = 8'h00;
                state_d = ZERO;
            end else begin
                acc_d   = sub_diff;
                state_d = (sub_diff == 8'h00) ? ZERO : RUN;
            end
`else
            acc_d   = sub_diff;
            state_d = (sub_diff == 8'h00) ? ZERO : RUN;
`endif
        end
    end

    always_comb begin
        done      = (state_q == ZERO);
        fsm_state = state_q;
        hex0      = seg_decode(a[3:0]);
        hex1      = seg_decode(a[7:4]);
        hex2      = seg_decode(acc[3:0]);
        hex3      = seg_decode(acc[7:4]);
    end

endmodule

// File: tb/tb_dec_accumulator.sv
// Self-checking bench for dec_accumulator: reference model feeds an expected
// queue of {acc, b, v, done, state}, compared one cycle after each edge.
module tb_dec_accumulator;
    import dec_accumulator_pkg::*;

    localparam int W = 13;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic       load;
    logic       step;
    logic [7:0] acc;
    logic       b;
    logic       v;
    logic       done;
    logic [6:0] hex0, hex1, hex2, hex3;
    state_t     fsm_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];

    logic [7:0] m_acc;
    logic       m_b, m_v;
    logic [1:0] m_st;

    dec_accumulator #(.INIT(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .load      (load),
        .step      (step),
        .acc       (acc),
        .b         (b),
        .v         (v),
        .done      (done),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic ld, input logic st, input logic [7:0] av);
        logic [7:0] diff;
        logic       nb, nv;
        if (r) begin
            m_acc = 8'h00; m_b = 1'b0; m_v = 1'b0; m_st = 2'd0;
        end else if (ld) begin
            m_acc = av; m_b = 1'b0; m_v = 1'b0;
            m_st  = (av == 8'h00) ? 2'd2 : 2'd1;
        end else if (st && m_st == 2'd1) begin
            diff = m_acc - av;
            nb   = (av > m_acc);
            nv   = (m_acc[7] != av[7]) && (diff[7] != m_acc[7]);
            m_b  = nb;
            m_v  = nv;
`ifdef DEC_ACC_SAT_EN
            if (nb) begin
                m_acc = 8'h00; m_st = 2'd2;
            end else begin
                m_acc = diff; m_st = (diff == 8'h00) ? 2'd2 : 2'd1;
            end
`else
            m_acc = diff;
            m_st  = (diff == 8'h00) ? 2'd2 : 2'd1;
`endif
        end
        exp_q.push_back({m_acc, m_b, m_v, (m_st == 2'd2), m_st});
    endtask

    task automatic cycle(input string tag, input logic r, input logic ld,
                         input logic st, input logic [7:0] av);
        logic [W-1:0] e;
        reset = r; load = ld; step = st; a = av;
        model(r, ld, st, av);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_acc"},   32'(acc),        32'(e[12:5]));
            check({tag, "_b"},     32'(b),          32'(e[4]));
            check({tag, "_v"},     32'(v),          32'(e[3]));
            check({tag, "_done"},  32'(done),       32'(e[2]));
            check({tag, "_state"}, 32'(fsm_state),  32'(e[1:0]));
            check({tag, "_hex2"},  32'(hex2),       32'(glyph(e[8:5])));
            check({tag, "_hex3"},  32'(hex3),       32'(glyph(e[12:9])));
        end
        check({tag, "_hex0"}, 32'(hex0), 32'(glyph(av[3:0])));
        check({tag, "_hex1"}, 32'(hex1), 32'(glyph(av[7:4])));
    endtask

    initial begin
        logic r, ld, st;
        logic [7:0] av;
        m_acc = 8'h00; m_b = 1'b0; m_v = 1'b0; m_st = 2'd0;
        reset = 1'b1; load = 1'b0; step = 1'b0; a = 8'h00;

        // Scenario 1: reset, then step in IDLE is ignored
        cycle("rst", 1, 0, 0, 8'h00);
        check("rst_acc_const", 32'(acc), 32'h00);
        check("rst_done_const", 32'(done), 32'd0);
        cycle("idle_step", 0, 0, 1, 8'h05);
        check("idle_acc_const", 32'(acc), 32'h00);

        // Scenario 2/3: load 0A, step by 3 three times, then 1 to reach zero
        cycle("load0a", 0, 1, 0, 8'h0A);
        cycle("s07", 0, 0, 1, 8'h03);
        check("s07_const", 32'(acc), 32'h07);
        cycle("s04", 0, 0, 1, 8'h03);
        cycle("s01", 0, 0, 1, 8'h03);
        check("s01_const", 32'(acc), 32'h01);
        cycle("s00", 0, 0, 1, 8'h01);
        check("zero_done_const", 32'(done), 32'd1);
        cycle("zero_ign", 0, 0, 1, 8'h01);

        // Scenario 4: borrowing step
        cycle("load02", 0, 1, 0, 8'h02);
        cycle("borrow", 0, 0, 1, 8'h05);
`ifndef DEC_ACC_SAT_EN
        check("borrow_const", 32'(acc), 32'hFD);
`endif
        // Step with a == 0 leaves acc alone
        cycle("a0_step", 0, 0, 1, 8'h00);

        // Scenario 5: signed overflow, then load/step priority
        cycle("load80", 0, 1, 0, 8'h80);
        cycle("ovf", 0, 0, 1, 8'h01);
        check("ovf_v_const", 32'(v), 32'd1);
        cycle("ld_st", 0, 1, 1, 8'h33);
        check("ld_st_const", 32'(acc), 32'h33);
        cycle("load_zero", 0, 1, 0, 8'h00);

        // Scenario 6: reset mid-sequence, then display check
        cycle("load44", 0, 1, 0, 8'h44);
        cycle("step44", 0, 0, 1, 8'h01);
        cycle("mid_rst", 1, 1, 1, 8'h44);
        cycle("post_rst", 0, 0, 1, 8'h02);
        cycle("load3c", 0, 1, 0, 8'h3C);
        check("hex2_3c", 32'(hex2), 32'h46);
        check("hex3_3c", 32'(hex3), 32'h30);

        // Random mix
        for (int i = 0; i < 200; i++) begin
            r  = ($urandom_range(0, 29) == 0);
            ld = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 3) != 0);
            av = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) av = 8'($urandom_range(0, 3));
            cycle("rand", r, ld, st, av);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dec_accumulator.md
DEC_ACCUMULATOR -- requirements
Module: dec_accumulator

Interface
REQ-001 Parameter: INIT, default 8'h00, value loaded into acc on reset.
REQ-002 clk  input  1  rising-edge clock; all state changes occur only on this edge.
REQ-003 reset  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
REQ-004 a  input  8  subtrahend / load operand (board switches).
REQ-005 load  input  1  when high at a clock edge, acc takes the value of a.
REQ-006 step  input  1  when high at a clock edge, acc takes the value acc - a.
REQ-007 acc  output  8  accumulator register (LEDs).
REQ-008 b  output  1  registered borrow of the last executed step.
REQ-009 v  output  1  registered signed (two's-complement) overflow of the last executed step.
REQ-010 done  output  1  high while the FSM is in state ZERO.
REQ-011 hex0, hex1  output  7 each  active-low segment patterns for a[3:0] and a[7:4].
REQ-012 hex2, hex3  output  7 each  active-low segment patterns for acc[3:0] and acc[7:4].

Function
REQ-013 The block SHALL contain a three-state FSM with states IDLE, RUN and ZERO.
REQ-014 In any state, load=1 SHALL set acc to a, clear b and v, and move the FSM to RUN (or to ZERO if a==0).
REQ-015 In RUN with step=1 and load=0, the block SHALL compute acc <= acc - a modulo 256.
REQ-016 On each executed step, b SHALL be set to (a > acc) as an unsigned comparison of the pre-step values.
REQ-017 On each executed step, v SHALL be set to (acc[7] != a[7]) && (result[7] != acc[7]).
REQ-018 After an executed step whose 8-bit result is 0, the FSM SHALL enter ZERO.
REQ-019 In IDLE and ZERO, step SHALL be ignored, and acc, b and v SHALL hold their values.
REQ-020 If load and step are both high, load SHALL take priority and step SHALL be discarded.
REQ-021 A step with a==0 in RUN SHALL leave acc unchanged and set b=0 and v=0.
REQ-022 acc, b, v and done SHALL update one cycle after the qualifying edge; there is no other latency.
REQ-023 hex0..hex3 SHALL be combinational decodes of values 0-F to the standard 7-segment glyphs, with segment g as bit 6.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL set acc=INIT, b=0, v=0 and state=IDLE, so done=0.
REQ-025 Reset SHALL override load and step, including in the middle of a step sequence.
REQ-026 In the first cycle after reset, step SHALL have no effect until a load has been performed.

Configuration
REQ-027 The macro DEC_ACC_SAT_EN, when defined, SHALL make a step with borrow clamp acc to 8'h00, set b=1, and enter ZERO.
REQ-028 When DEC_ACC_SAT_EN is not defined, a borrowing step SHALL wrap modulo 256 and the FSM SHALL remain in RUN unless the result is 0.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, ZERO=2'd2) and the 16-entry 7-segment glyph constants.
REQ-030 The subtraction SHALL be implemented in one sub-module, full_sub_8_bit, with outputs diff[7:0], borrow and overflow.
REQ-031 The four display decoders SHALL be four instances of a single shared decode function or task.

Verification
REQ-032 Scenario 1: apply reset -> acc=8'h00, b=0, v=0, done=0; then pulse step with a=8'h05 -> acc stays 8'h00.
REQ-033 Scenario 2: load a=8'h0A, then step with a=8'h03 for three edges -> acc=8'h07, then 8'h04, then 8'h01, with b=0 and done=0 throughout.
REQ-034 Scenario 3: acc=8'h01, step with a=8'h01 -> acc=8'h00 and done=1; a further step is ignored.
REQ-035 Scenario 4: acc=8'h02, step with a=8'h05 -> acc=8'hFD, b=1, FSM in RUN; with DEC_ACC_SAT_EN defined -> acc=8'h00, b=1, done=1.
REQ-036 Scenario 5: acc=8'h80, step with a=8'h01 -> acc=8'h7F, v=1, b=0; load and step high together with a=8'h33 -> acc=8'h33.
REQ-037 Scenario 6: assert reset mid-sequence with acc=8'h44 -> acc=INIT and state IDLE next cycle; hex2/hex3 decode acc=8'h3C as 7'b1000110 / 7'b0110000.
